// File: rtl/cmd_data_controller_if.sv
// rtl/cmd_data_controller_if.sv - UART/memory side signal bundle for cmd_data_controller
interface cmd_data_controller_if #(
  parameter int ADDR_W = 8
) ();
  logic              new_data_rx;
  logic [7:0]        data_rx;
  logic              busy;
  logic              new_data_tx;
  logic [7:0]        data_tx;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              drop;
  logic [7:0]        debug;
  logic              active;

  // Controller side
  modport master (
    input  new_data_rx, data_rx, busy, rd_data,
    output new_data_tx, data_tx, addr, wr_en, wr_addr, wr_data, drop, debug, active
  );

  // UART / memory / environment side
  modport slave (
    output new_data_rx, data_rx, busy, rd_data,
    input  new_data_tx, data_tx, addr, wr_en, wr_addr, wr_data, drop, debug, active
  );
endinterface

// File: rtl/cmd_data_controller.sv
// rtl/cmd_data_controller.sv - UART command decoder driving memory reads, bursts and register writes
module cmd_data_controller #(
  parameter int         ADDR_W   = 8,
  parameter int         DEPTH    = 25,
  parameter int         TIMEOUT  = 50000,
  parameter logic [7:0] ACK_BYTE = 8'hAA,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input logic                   clk,
  input logic                   rst,
  cmd_data_controller_if.master bus
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Address math is one bit wider so start+count can never wrap past DEPTH.
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W    = (ADDR_W+1)'(1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   TMO_ONE  = TW'(1);

  localparam logic [7:0] CMD_READ  = 8'h04;
  localparam logic [7:0] CMD_BURST = 8'h05;
  localparam logic [7:0] CMD_RANGE = 8'h06;
  localparam logic [7:0] CMD_WRITE = 8'h07;
  localparam logic [7:0] CMD_DROP  = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE, S_ARG, S_SETTLE, S_TX_WAIT, S_TX_GAP, S_NEXT, S_WRITE
  } state_t;

  typedef enum logic [1:0] {OP_READ, OP_RANGE, OP_WRITE} op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic              arg_idx_q, arg_idx_d;
  logic [ADDR_W:0]   arg0_q, arg0_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              burst_q, burst_d;
  logic              use_const_q, use_const_d;
  logic [7:0]        const_q, const_d;
  logic              tx_stb_q, tx_stb_d;
  logic [7:0]        data_tx_q, data_tx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              drop_q, drop_d;
  logic [7:0]        debug_q, debug_d;
  logic [ADDR_W:0]   rx_arg;

  // Argument bytes contribute only their low ADDR_W bits, zero-extended.
  assign rx_arg = {1'b0, ADDR_W'(bus.data_rx)};

  // State and output registers; async reset zeroes every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      arg_idx_q   <= 1'b0;
      arg0_q      <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      tmo_q       <= '0;
      burst_q     <= 1'b0;
      use_const_q <= 1'b0;
      const_q     <= '0;
      tx_stb_q    <= 1'b0;
      data_tx_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      drop_q      <= 1'b0;
      debug_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      arg_idx_q   <= arg_idx_d;
      arg0_q      <= arg0_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      tmo_q       <= tmo_d;
      burst_q     <= burst_d;
      use_const_q <= use_const_d;
      const_q     <= const_d;
      tx_stb_q    <= tx_stb_d;
      data_tx_q   <= data_tx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      drop_q      <= drop_d;
      debug_q     <= debug_d;
    end
  end

  // Command decode, argument collection, transmit pacing and burst sequencing.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg_idx_d   = arg_idx_q;
    arg0_d      = arg0_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    tmo_d       = tmo_q;
    burst_d     = burst_q;
    use_const_d = use_const_q;
    const_d     = const_q;
    tx_stb_d    = 1'b0;
    data_tx_d   = data_tx_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    drop_d      = drop_q;
    debug_d     = debug_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.new_data_rx) begin
          arg_idx_d = 1'b0;
          tmo_d     = '0;
          case (bus.data_rx)
            CMD_READ:  begin op_d = OP_READ;  state_d = S_ARG; end
            CMD_RANGE: begin op_d = OP_RANGE; state_d = S_ARG; end
            CMD_WRITE: begin op_d = OP_WRITE; state_d = S_ARG; end
            CMD_BURST: begin
              addr_d      = '0;
              rem_d       = DEPTH_W;
              burst_d     = 1'b1;
              use_const_d = 1'b0;
              state_d     = S_SETTLE;
            end
            CMD_DROP: begin
              drop_d = ~drop_q;
              addr_d = '0;
            end
            default: debug_d = bus.data_rx;
          endcase
        end
      end

      S_ARG: begin
        if (bus.new_data_rx) begin
          // A byte arriving on the timeout cycle still counts and restarts the timer.
          tmo_d = '0;
          if (!arg_idx_q && op_q != OP_READ) begin
            arg0_d    = rx_arg;
            arg_idx_d = 1'b1;
          end else begin
            burst_d     = 1'b0;
            use_const_d = 1'b0;
            case (op_q)
              OP_READ: begin
                if (rx_arg < DEPTH_W) begin
                  addr_d  = rx_arg;
                  state_d = S_SETTLE;
                end else begin
                  use_const_d = 1'b1;
                  const_d     = ERR_BYTE;
                  state_d     = S_TX_WAIT;
                end
              end
              OP_RANGE: begin
                if (rx_arg == '0 || arg0_q >= DEPTH_W) begin
                  state_d = S_IDLE;
                end else begin
                  addr_d  = arg0_q;
                  rem_d   = rx_arg;
                  burst_d = 1'b1;
                  state_d = S_SETTLE;
                end
              end
              default: begin
                use_const_d = 1'b1;
                if (arg0_q < DEPTH_W) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = arg0_q[ADDR_W-1:0];
                  wr_data_d = bus.data_rx;
                  const_d   = ACK_BYTE;
                  state_d   = S_WRITE;
                end else begin
                  const_d = ERR_BYTE;
                  state_d = S_TX_WAIT;
                end
              end
            endcase
          end
        end else if (tmo_q == TMO_LAST) begin
          debug_d = 8'hFF;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      S_WRITE:  state_d = S_TX_WAIT;

      S_SETTLE: state_d = S_TX_WAIT;

      S_TX_WAIT: begin
        if (!bus.busy) begin
          tx_stb_d  = 1'b1;
          data_tx_d = use_const_q ? const_q : bus.rd_data;
          state_d   = S_TX_GAP;
        end
      end

      S_TX_GAP: state_d = burst_q ? S_NEXT : S_IDLE;

      S_NEXT: begin
        if (rem_q <= ONE_W || addr_q + ONE_W == DEPTH_W) begin
          addr_d  = '0;
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + ONE_W;
          rem_d   = rem_q - ONE_W;
          state_d = S_SETTLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.new_data_tx = tx_stb_q;
  assign bus.data_tx     = data_tx_q;
  assign bus.addr        = addr_q[ADDR_W-1:0];
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.drop        = drop_q;
  assign bus.debug       = debug_q;
  assign bus.active      = (state_q != S_IDLE);
endmodule

// File: doc/cmd_data_controller.md
# cmd_data_controller

Parametrised command processor between the UART receiver/transmitter pair and the sample/register memory. It decodes single-byte commands from the RX stream, collects argument bytes with an inactivity timeout, and performs:
- single reads, full bursts and ranged bursts to TX;
- register writes with an acknowledge byte;
- the drop toggle.

It generalises the original fixed 25-entry controller in depth and address width and adds ranged bursts, writes, bounds checking and timeouts.

## Interface
Parameters:
- ADDR_W, 8, width of addr/wr_addr; DEPTH must be ≤ 2^ADDR_W.
- DEPTH, 25, number of valid memory locations (0..DEPTH-1).
- TIMEOUT, 50000, clk cycles of RX silence tolerated while collecting arguments; ≥ 2.
- ACK_BYTE, 8'hAA, byte sent after a successful write.
- ERR_BYTE, 8'hEE, byte sent for an out-of-range read/write.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- new_data_rx  in  1  one-cycle strobe, data_rx valid.
- data_rx  in  8  received byte.
- busy  in  1  transmitter busy; no new_data_tx while high.
- new_data_tx  out  1  one-cycle strobe, data_tx valid same cycle.
- data_tx  out  8  byte to transmit.
- addr  out  ADDR_W  memory read address (registered).
- rd_data  in  8  memory read data, combinational from addr, valid the cycle after addr changes.
- wr_en  out  1  one-cycle memory write strobe.
- wr_addr  out  ADDR_W  write address, valid with wr_en.
- wr_data  out  8  write data, valid with wr_en.
- drop  out  1  drop-mode flag, toggled by command.
- debug  out  8  last unrecognised command byte.
- active  out  1  high whenever the FSM is not in IDLE.

## Operation
- Reset values: every output is 0, and the FSM is in IDLE.
- Commands (decoded only in IDLE, on new_data_rx):
  - 0x04 READ: arg addr. If addr < DEPTH, send rd_data[addr]; otherwise send ERR_BYTE.
  - 0x05 BURST: send locations 0..DEPTH-1 in order.
  - 0x06 RANGE: args start, count (ADDR_W bits each, taken from the low bits of data_rx).
    - Sends locations start..start+count-1, stopping early at DEPTH.
    - count=0 or start≥DEPTH: nothing is sent and the FSM returns to IDLE.
  - 0x07 WRITE: args wa, wd.
    - wa < DEPTH: pulse wr_en with wr_addr=wa and wr_data=wd, then send ACK_BYTE.
    - Otherwise: no write, send ERR_BYTE.
  - 0x42 DROP: drop <= ~drop and addr <= 0; no TX.
  - Any other byte: debug <= data_rx; stay in IDLE.
- States:
  - IDLE
  - ARG (collects 1 or 2 argument bytes; an arg index tracks progress)
  - SETTLE (addr just updated; wait 1 cycle for rd_data)
  - TX_WAIT (wait !busy, then strobe)
  - TX_GAP (1 cycle after each strobe so busy can rise)
  - NEXT (burst advance/limit check)
  - WRITE (wr_en pulse)
- Burst flow: SETTLE→TX_WAIT→TX_GAP→NEXT.
  - NEXT increments addr and decrements the remaining count.
  - When remaining is 0 or addr+1 == DEPTH, NEXT goes to IDLE with addr <= 0; otherwise it goes to SETTLE.
- The address counter is ADDR_W+1 bits internally, so start+count never wraps. The limit compare uses the full width.
- Timeout: in ARG, a counter resets on each new_data_rx. If it reaches TIMEOUT-1, the FSM returns to IDLE, discards partial args, sets debug <= 8'hFF, and sends nothing.
- In all states other than IDLE and ARG, new_data_rx is ignored. Commands are not queued.

## Timing
- new_data_tx is high exactly one cycle per transmitted byte, and only in a cycle where busy was sampled low.
- Consecutive strobes are separated by ≥ 2 cycles.
- READ: the strobe comes 3 cycles after the addr byte strobe when busy=0 (ARG→SETTLE→TX_WAIT→strobe).
- BURST/RANGE: with busy held 0, the strobes are 4 cycles apart. busy high in TX_WAIT stalls without limit; data_tx and addr are held.
- WRITE: wr_en is asserted in the cycle after the wd strobe. The ACK strobe follows when busy is low, ≥ 1 cycle after wr_en.
- new_data_rx in the same cycle as a timeout: the byte wins, and the counter resets.
- rst mid-operation: the FSM returns to IDLE immediately and all outputs are zeroed. Any partial burst is abandoned, and no wr_en is produced.

## Test plan
- Reset, then RX 0x04, 0x03 with rd_data=mem[3]=0x5C and busy=0 → one strobe with data_tx=0x5C, then IDLE, active=0.
- RX 0x05 with DEPTH=25, busy toggling high 10 cycles after each strobe → exactly 25 strobes carrying mem[0..24] in order, then addr=0.
- RX 0x06, 0x16, 0x08 (DEPTH=25) → 3 strobes (addr 22, 23, 24). RX 0x06, 0x02, 0x00 → no strobe, back to IDLE.
- RX 0x07, 0x05, 0x9A → wr_en one cycle with wr_addr=5 and wr_data=0x9A, then data_tx=0xAA. RX 0x07, 0x30, 0x11 → no wr_en, data_tx=0xEE. RX 0x04, 0x30 → data_tx=0xEE.
- RX 0x07, 0x05, then silence for TIMEOUT cycles → IDLE, debug=0xFF, no wr_en, no strobe. Next, RX 0x42 → drop=1; RX 0x42 again → drop=0; RX 0x13 → debug=0x13.
- Assert rst during the 10th burst byte → outputs zero that cycle. After release, a fresh 0x04 command works normally.
